// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: forwarding select codes,
// register-index width and the pipeline tracking-slot records.
package hazard_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             wen;
        logic             load;
    } slot_t;

    // The load flag only matters while the producer sits in EX, so MEM drops it.
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             wen;
    } mem_slot_t;

    // The youngest in-flight writer wins.
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit)
            return FWD_EXMEM;
        else if (mem_hit)
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one source register against one tracked writer; x0 never matches.
module hazard_match
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] rd,
    input  logic             wen,
    output logic             hit
);

    assign hit = wen && (rd != '0) && (rd == src);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall and EX/MEM forwarding control for a five-stage pipeline,
// with a saturating count of stall cycles.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_wen,
    input  logic             id_load,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    slot_t     ex_q;
    mem_slot_t mem_q;

    logic rs1_ex_hit;
    logic rs2_ex_hit;
    logic rs1_mem_hit;
    logic rs2_mem_hit;
    logic bubble;

    hazard_match u_rs1_ex (
        .src (id_rs1),
        .rd  (ex_q.rd),
        .wen (ex_q.wen),
        .hit (rs1_ex_hit)
    );

    hazard_match u_rs2_ex (
        .src (id_rs2),
        .rd  (ex_q.rd),
        .wen (ex_q.wen),
        .hit (rs2_ex_hit)
    );

    hazard_match u_rs1_mem (
        .src (id_rs1),
        .rd  (mem_q.rd),
        .wen (mem_q.wen),
        .hit (rs1_mem_hit)
    );

    hazard_match u_rs2_mem (
        .src (id_rs2),
        .rd  (mem_q.rd),
        .wen (mem_q.wen),
        .hit (rs2_mem_hit)
    );

    // A squashed instruction cannot create a hazard, so flush masks the stall.
    assign stall  = !flush && ex_q.load && (rs1_ex_hit || rs2_ex_hit);
    assign bubble = stall || flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            fwd_a     <= FWD_RF;
            fwd_b     <= FWD_RF;
            stall_cnt <= '0;
        end else begin
            mem_q.rd  <= ex_q.rd;
            mem_q.wen <= ex_q.wen;
            if (bubble) begin
                ex_q  <= '0;
                fwd_a <= FWD_RF;
                fwd_b <= FWD_RF;
            end else begin
                ex_q.rd   <= id_rd;
                ex_q.wen  <= id_wen;
                ex_q.load <= id_load;
                fwd_a     <= fwd_sel(rs1_ex_hit, rs1_mem_hit);
                fwd_b     <= fwd_sel(rs2_ex_hit, rs2_mem_hit);
            end
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios then random
// traffic, checked against an in-flight instruction list model.
module tb_hazard_ctrl;

    localparam int CNT_W = 2;

    typedef struct {
        logic [4:0] rd;
        bit         wen;
        bit         load;
    } instr_t;

    typedef struct {
        bit             stall;
        logic [1:0]     fa;
        logic [1:0]     fb;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic             id_wen;
    logic             id_load;
    logic             flush;
    logic             stall;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .id_rd     (id_rd),
        .id_wen    (id_wen),
        .id_load   (id_load),
        .flush     (flush),
        .stall     (stall),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t   sb[$];
    instr_t pipe[$];
    logic [1:0] m_fa;
    logic [1:0] m_fb;
    int     m_cnt;
    int     total;
    int     bad;
    bit     last_stall;

    // pipe[0] is the instruction in EX, pipe[1] the one in MEM.
    function automatic bit writes(input instr_t i, input logic [4:0] r);
        return i.wen && (r != 5'd0) && (i.rd == r);
    endfunction

    function automatic logic [1:0] youngest(input logic [4:0] r);
        for (int k = 0; k < 2; k++)
            if (writes(pipe[k], r))
                return (k == 0) ? 2'd1 : 2'd2;
        return 2'd0;
    endfunction

    function automatic void model_reset();
        instr_t b;
        b.rd = 5'd0; b.wen = 1'b0; b.load = 1'b0;
        pipe.delete();
        pipe.push_back(b);
        pipe.push_back(b);
        m_fa  = 2'd0;
        m_fb  = 2'd0;
        m_cnt = 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input bit wen, input bit load,
                                 input bit fl, input bit r);
        exp_t   e;
        instr_t ni;
        instr_t b;
        @(negedge clk);
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_wen = wen; id_load = load; flush = fl; rst = r;

        e.stall = !fl && pipe[0].load && (writes(pipe[0], rs1) || writes(pipe[0], rs2));
        e.fa    = m_fa;
        e.fb    = m_fb;
        e.cnt   = CNT_W'(m_cnt);
        sb.push_back(e);
        last_stall = e.stall;

        if (r) begin
            model_reset();
        end else begin
            if (e.stall && m_cnt < (1 << CNT_W) - 1)
                m_cnt++;
            b.rd = 5'd0; b.wen = 1'b0; b.load = 1'b0;
            ni.rd = rd; ni.wen = wen; ni.load = load;
            if (e.stall || fl) begin
                m_fa = 2'd0;
                m_fb = 2'd0;
                pipe.push_front(b);
            end else begin
                m_fa = youngest(rs1);
                m_fb = youngest(rs2);
                pipe.push_front(ni);
            end
            void'(pipe.pop_back());
        end
    endtask

    // Monitor: every cycle the DUT presents a response, compare the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("stall", int'(stall), int'(e.stall));
                checkOutput("fwd_a", int'(fwd_a), int'(e.fa));
                checkOutput("fwd_b", int'(fwd_b), int'(e.fb));
                checkOutput("stall_cnt", int'(stall_cnt), int'(e.cnt));
            end
        end
    end

    initial begin
        logic [4:0] rs1, rs2, rd;
        bit wen, load, fl, r;
        int waited;
        total = 0;
        bad   = 0;
        last_stall = 1'b0;
        rst = 1'b1; flush = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_wen = 1'b0; id_load = 1'b0;
        model_reset();

        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Back-to-back EX forwarding.
        applyStimulus(0, 0, 5, 1, 0, 0, 0);
        applyStimulus(5, 0, 6, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Distance two, then writers in both EX and MEM.
        applyStimulus(0, 0, 7, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 7, 8, 1, 0, 0, 0);
        applyStimulus(0, 0, 7, 1, 0, 0, 0);
        applyStimulus(0, 0, 7, 1, 0, 0, 0);
        applyStimulus(0, 7, 8, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Load-use: one stall, then MEM/WB forwarding.
        applyStimulus(0, 0, 3, 1, 1, 0, 0);
        applyStimulus(3, 0, 9, 1, 0, 0, 0);
        applyStimulus(3, 0, 9, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // x0 never forwards; flush masks a load-use.
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 4, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 4, 1, 1, 0, 0);
        applyStimulus(4, 0, 2, 1, 0, 1, 0);
        applyStimulus(4, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Counter saturation, then reset mid-stall.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 3, 1, 1, 0, 0);
            applyStimulus(0, 3, 9, 1, 0, 0, 0);
            applyStimulus(0, 3, 9, 1, 0, 0, 0);
        end
        applyStimulus(0, 0, 9, 1, 1, 0, 0);
        applyStimulus(9, 0, 1, 1, 0, 0, 1);
        applyStimulus(9, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        rs1 = '0; rs2 = '0; rd = '0; wen = 1'b0; load = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                rs1  = 5'($urandom_range(0, 7));
                rs2  = 5'($urandom_range(0, 7));
                rd   = 5'($urandom_range(0, 7));
                wen  = ($urandom_range(0, 3) != 0);
                load = wen && ($urandom_range(0, 2) == 0);
            end
            fl = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 59) == 0);
            applyStimulus(rs1, rs2, rd, wen, load, fl, r);
        end

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        #5;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 16, width of the stall performance counter.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 id_rs1  input  5  source register 1 of the instruction in ID.
REQ-005 id_rs2  input  5  source register 2 of the instruction in ID.
REQ-006 id_rd  input  5  destination register of the instruction in ID.
REQ-007 id_wen  input  1  the ID instruction writes the register file.
REQ-008 id_load  input  1  the ID instruction is a load (data available only at end of MEM).
REQ-009 flush  input  1  branch/jump redirect; the ID instruction is squashed.
REQ-010 stall  output  1  combinational; holds PC and the IF/ID register and injects a bubble into EX.
REQ-011 fwd_a  output  2  registered; operand-A forwarding select for the instruction now in EX.
REQ-012 fwd_b  output  2  registered; operand-B forwarding select for the instruction now in EX.
REQ-013 stall_cnt  output  CNT_W  number of stall cycles since reset.

Function
REQ-014 The block SHALL keep two internal tracking slots, EX and MEM, each holding {rd[4:0], wen, load}.
REQ-015 Each cycle, MEM SHALL take the old EX contents, and EX SHALL take the ID fields.
REQ-016 When stall or flush is 1, EX SHALL instead take a bubble {0,0,0}.
REQ-017 A source matches a slot only when: slot.wen=1, slot.rd!=0, and slot.rd equals the source; register x0 SHALL never match.
REQ-018 stall SHALL be 1 when flush=0, the EX slot has load=1, and id_rs1 or id_rs2 matches the EX slot.
REQ-019 flush SHALL have priority over stall: when flush=1, stall SHALL be 0.
REQ-020 fwd select encoding SHALL be: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result; 11 SHALL never be produced.
REQ-021 On a clock edge without stall or flush, fwd_a SHALL register 01 if id_rs1 matches EX, else 10 if it matches MEM, else 00; fwd_b SHALL do the same with id_rs2.
REQ-022 Priority: an EX match SHALL win over a MEM match (youngest writer wins).
REQ-023 On a clock edge with stall or flush, fwd_a and fwd_b SHALL register 00 (they describe the bubble).
REQ-024 Latency: a select computed in ID SHALL be visible exactly one cycle later, aligned with the instruction in EX.
REQ-025 No WB-stage forwarding: the register file writes before it is read within a cycle.
REQ-026 A load-use hazard SHALL cost exactly one stall cycle; the re-evaluated instruction then matches the MEM slot and gets fwd=10.
REQ-027 stall_cnt SHALL increment by 1 on each edge where stall=1, and SHALL saturate at all-ones with no wrap-around.

Reset
REQ-028 With rst=1 at an edge: both slots SHALL become {0,0,0}, fwd_a=fwd_b=00, and stall_cnt=0.
REQ-029 stall SHALL be 0 in the cycle after reset, because the EX slot is empty.
REQ-030 rst SHALL override flush and stall on the same edge, including a reset asserted mid-stall.

Structure
REQ-031 A shared package hazard_pkg SHALL hold the FWD_RF, FWD_EXMEM, FWD_MEMWB localparams and the slot-record field widths.
REQ-032 One sub-module, hazard_match (combinational: source, rd, wen -> hit), SHALL be instantiated four times (rs1/rs2 x EX/MEM).

Verification
REQ-033 Back-to-back dependency: add x5 (wen=1), then add rs1=x5 -> next cycle fwd_a=01, stall=0.
REQ-034 Distance two: add x7, then nop, then rs2=x7 -> fwd_b=10; with writers to x7 in both EX and MEM -> fwd_b=01.
REQ-035 Load-use: lw x3, then rs1=x3 -> stall=1 for exactly one cycle, stall_cnt 0->1, then fwd_a=10.
REQ-036 x0 and flush: a writer to x0 followed by rs1=x0 -> fwd_a=00; load-use coinciding with flush=1 -> stall=0 and bubble inserted.
REQ-037 Saturation and reset: with CNT_W=2, four load-use stalls -> stall_cnt stays 3; rst=1 during a stall -> all outputs 0 on the next cycle.
